rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single read port of one genrom instance between two requesters: requester 0 is core instruction/immediate fetch, requester 1 is a loader/debug reader.
- Arbitration is round-robin with a request/ready/response handshake. Each requester supplies its own bounds window, which is forwarded to the ROM.
- Sits between the requesters and the genrom read port, in place of a direct core-to-ROM connection.

Parameters:
- MEM_ADDR, 6, address msb index; all addresses and bounds are MEM_ADDR+1 bits wide.
- MEM_EXTRA, 4, width of the extra (access size) field; data width is 2**MEM_EXTRA*8.
- ROM_LATENCY, 1, clock edges from mem_addr valid to mem_data/mem_error valid (1..7).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rq_valid  in  2  per-requester request strobe; held until accepted
- rq_addr  in  2*(MEM_ADDR+1)  per-requester address; slice i belongs to requester i
- rq_extra  in  2*MEM_EXTRA  per-requester extra field
- rq_lower_bound  in  2*(MEM_ADDR+1)  per-requester lower bound
- rq_upper_bound  in  2*(MEM_ADDR+1)  per-requester upper bound
- rq_ready  out  2  one-hot acceptance pulse
- rs_valid  out  2  one-hot response pulse
- rs_data  out  2**MEM_EXTRA*8  response data, shared by both requesters
- rs_error  out  1  response error, qualified by rs_valid
- mem_addr  out  MEM_ADDR+1  to ROM addr
- mem_extra  out  MEM_EXTRA  to ROM extra
- mem_lower_bound  out  MEM_ADDR+1  to ROM lower_bound
- mem_upper_bound  out  MEM_ADDR+1  to ROM upper_bound
- mem_data  in  2**MEM_EXTRA*8  from ROM
- mem_error  in  1  from ROM

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; rq_ready=0; rs_valid=0; rs_data=0; rs_error=0.
  - mem_addr, mem_extra and mem_lower_bound = 0; mem_upper_bound = all ones.
  - last_grant=1, so requester 0 has priority on the first contest.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If any rq_valid is set, grant one and assert rq_ready[g] combinationally in that cycle.
  - On the edge, latch rq_addr/extra/bounds of g into the mem_* registers and go to WAIT with counter = ROM_LATENCY-1.
  - Round-robin: if both are valid, grant !last_grant; if one is valid, grant it. last_grant updates on each grant.
- WAIT:
  - mem_* held stable; counter decrements.
  - On the edge where counter==0, capture mem_data/mem_error into rs_data/rs_error and go to RESP.
- RESP:
  - rs_valid[g]=1 for exactly one cycle; rs_data/rs_error are valid in that cycle.
  - Arbitration for the next request is evaluated in this same cycle (RESP behaves as IDLE for acceptance), so back-to-back accesses cost ROM_LATENCY+1 cycles each.
  - With no request pending, go to IDLE.
- Latency: the response is high during cycle A+ROM_LATENCY+1, where A is the accepting edge. With ROM_LATENCY=1, accept in cycle 0 gives rs_valid in cycle 2.
- Outside WAIT, mem_* hold the last latched values (no toggling while idle). rs_data/rs_error hold their value after the pulse.
- rq_valid dropped before acceptance: the request is withdrawn with no side effect. Changing a request's fields while rq_valid is high and not yet accepted is allowed; the values sampled at acceptance are the ones used.
- At most one outstanding access; no rq_ready is issued while in WAIT.
- mem_error is passed through unmodified; the arbiter performs no bounds checking itself.
- Reset mid-operation: the access is aborted, no rs_valid, and last_grant returns to 1.

Test Plan:
- Single request from requester 0: addr=17, extra=0, bounds 0..127, ROM_LATENCY=1 -> rq_ready[0] in cycle 0, mem_addr=17 from cycle 1, rs_valid=2'b01 in cycle 2 with rs_data=ROM[17], rs_error=0.
- Both requesters valid continuously (r0 addr=4, r1 addr=9) -> grants alternate 0,1,0,1; responses every 2 cycles with matching data; no grant is skipped.
- Requester 1 with bounds 20..30 and addr=40 -> mem_lower_bound=20, mem_upper_bound=30 during WAIT; rs_error=1 with rs_valid[1].
- ROM_LATENCY=3 -> mem_addr stable for 3 cycles; rs_valid at accept+4; requests arriving during WAIT see rq_ready=0 until RESP.
- Reset asserted mid-WAIT, asynchronously between edges -> all outputs return to reset values immediately, no rs_valid ever; after release, a simultaneous request grants requester 0 first.
- Request withdrawn (rq_valid[1] pulses low before acceptance while requester 0 is in flight) -> no access for requester 1; the next accepted request follows round-robin order.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//   Shares the single read port of one genrom between two requesters
//   (0: core fetch, 1: loader/debug). Round-robin arbitration with a
//   request/ready/response handshake; each requester's bounds window is
//   forwarded to the ROM along with its address and extra field.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   rq_valid/addr/extra/lower_bound/upper_bound
//                       per-requester request, slice i = requester i
//   rq_ready            one-hot acceptance (combinational in IDLE/RESP)
//   rs_valid            one-hot single-cycle response strobe
//   rs_data, rs_error   response payload, held after the strobe
//   mem_*               registered ROM read-port drive
//   mem_data, mem_error ROM read result
module rom_port_arbiter #(
    parameter int MEM_ADDR    = 6,
    parameter int MEM_EXTRA   = 4,
    parameter int ROM_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [1:0]                      rq_valid,
    input  logic [2*(MEM_ADDR+1)-1:0]       rq_addr,
    input  logic [2*MEM_EXTRA-1:0]          rq_extra,
    input  logic [2*(MEM_ADDR+1)-1:0]       rq_lower_bound,
    input  logic [2*(MEM_ADDR+1)-1:0]       rq_upper_bound,
    output logic [1:0]                      rq_ready,
    output logic [1:0]                      rs_valid,
    output logic [(2**MEM_EXTRA)*8-1:0]     rs_data,
    output logic                            rs_error,
    output logic [MEM_ADDR:0]               mem_addr,
    output logic [MEM_EXTRA-1:0]            mem_extra,
    output logic [MEM_ADDR:0]               mem_lower_bound,
    output logic [MEM_ADDR:0]               mem_upper_bound,
    input  logic [(2**MEM_EXTRA)*8-1:0]     mem_data,
    input  logic                            mem_error
);

    localparam int AW = MEM_ADDR + 1;
    localparam int EW = MEM_EXTRA;
    localparam int DW = (2**MEM_EXTRA) * 8;
    localparam int CW = 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;   // requester granted most recently
    logic            gnt_q, gnt_d;     // owner of the outstanding access
    logic [AW-1:0]   addr_q, addr_d;
    logic [EW-1:0]   extra_q, extra_d;
    logic [AW-1:0]   lb_q, lb_d;
    logic [AW-1:0]   ub_q, ub_d;
    logic [DW-1:0]   data_q, data_d;
    logic            err_q, err_d;
    logic            g;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            addr_q  <= '0;
            extra_q <= '0;
            lb_q    <= '0;
            ub_q    <= '1;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            extra_q <= extra_d;
            lb_q    <= lb_d;
            ub_q    <= ub_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        extra_d  = extra_q;
        lb_d     = lb_q;
        ub_d     = ub_q;
        data_d   = data_q;
        err_d    = err_q;
        rq_ready = '0;
        rs_valid = '0;
        // Both valid: hand over to the requester not served last time.
        g        = (&rq_valid) ? ~last_q : rq_valid[1];

        case (state_q)
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = mem_data;
                    err_d   = mem_error;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IDLE, RESP: begin
                // RESP also accepts, so back-to-back accesses overlap the
                // response cycle with the next grant.
                if (state_q == RESP) rs_valid[gnt_q] = 1'b1;
                state_d = IDLE;
                if (|rq_valid) begin
                    rq_ready[g] = 1'b1;
                    gnt_d       = g;
                    last_d      = g;
                    addr_d      = g ? rq_addr[2*AW-1:AW]        : rq_addr[AW-1:0];
                    extra_d     = g ? rq_extra[2*EW-1:EW]       : rq_extra[EW-1:0];
                    lb_d        = g ? rq_lower_bound[2*AW-1:AW] : rq_lower_bound[AW-1:0];
                    ub_d        = g ? rq_upper_bound[2*AW-1:AW] : rq_upper_bound[AW-1:0];
                    cnt_d       = CW'(ROM_LATENCY - 1);
                    state_d     = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rs_data         = data_q;
    assign rs_error        = err_q;
    assign mem_addr        = addr_q;
    assign mem_extra       = extra_q;
    assign mem_lower_bound = lb_q;
    assign mem_upper_bound = ub_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
module tb_rom_port_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   rq_valid;
    logic [13:0]  rq_addr;
    logic [7:0]   rq_extra;
    logic [13:0]  rq_lb;
    logic [13:0]  rq_ub;

    // Instance 0 runs ROM_LATENCY=1, instance 1 ROM_LATENCY=3; both see the
    // same request stream and are checked against their own model.
    logic [1:0]   rdy   [2];
    logic [1:0]   rsv   [2];
    logic [127:0] rsd   [2];
    logic         rse   [2];
    logic [6:0]   maddr [2];
    logic [3:0]   mext  [2];
    logic [6:0]   mlb   [2];
    logic [6:0]   mub   [2];
    logic [127:0] mdata [2];
    logic         merr  [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    function automatic logic [127:0] rom_f(input logic [6:0] a, input logic [3:0] e);
        logic [127:0] x;
        x = 128'({a, e}) + 128'd1;
        return x * 128'h9E3779B97F4A7C15F39CC0605CEDC835;
    endfunction

    // Behavioural genrom: result depends only on the stable mem_* drive.
    assign mdata[0] = rom_f(maddr[0], mext[0]);
    assign merr[0]  = (maddr[0] < mlb[0]) || (maddr[0] > mub[0]);
    assign mdata[1] = rom_f(maddr[1], mext[1]);
    assign merr[1]  = (maddr[1] < mlb[1]) || (maddr[1] > mub[1]);

    rom_port_arbiter #(.MEM_ADDR(6), .MEM_EXTRA(4), .ROM_LATENCY(1)) u_dut0 (
        .clk(clk), .reset(reset), .rq_valid(rq_valid), .rq_addr(rq_addr),
        .rq_extra(rq_extra), .rq_lower_bound(rq_lb), .rq_upper_bound(rq_ub),
        .rq_ready(rdy[0]), .rs_valid(rsv[0]), .rs_data(rsd[0]), .rs_error(rse[0]),
        .mem_addr(maddr[0]), .mem_extra(mext[0]), .mem_lower_bound(mlb[0]),
        .mem_upper_bound(mub[0]), .mem_data(mdata[0]), .mem_error(merr[0]));

    rom_port_arbiter #(.MEM_ADDR(6), .MEM_EXTRA(4), .ROM_LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset), .rq_valid(rq_valid), .rq_addr(rq_addr),
        .rq_extra(rq_extra), .rq_lower_bound(rq_lb), .rq_upper_bound(rq_ub),
        .rq_ready(rdy[1]), .rs_valid(rsv[1]), .rs_data(rsd[1]), .rs_error(rse[1]),
        .mem_addr(maddr[1]), .mem_extra(mext[1]), .mem_lower_bound(mlb[1]),
        .mem_upper_bound(mub[1]), .mem_data(mdata[1]), .mem_error(merr[1]));

    // Transaction-level model: an access accepted in cycle c answers in
    // cycle c+L+1, and that same cycle is the earliest next acceptance.
    int           last_g  [2];
    int           free_at [2];
    int           resp_at [2];
    int           resp_g  [2];
    logic [6:0]   e_addr  [2];
    logic [3:0]   e_ext   [2];
    logic [6:0]   e_lb    [2];
    logic [6:0]   e_ub    [2];
    logic [127:0] e_data  [2];
    logic         e_err   [2];
    logic [127:0] p_data  [2];
    logic         p_err   [2];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_g[k]  = 1;
            free_at[k] = 0;
            resp_at[k] = -1;
            e_addr[k]  = '0;
            e_ext[k]   = '0;
            e_lb[k]    = '0;
            e_ub[k]    = '1;
            e_data[k]  = '0;
            e_err[k]   = 1'b0;
        end
    endtask

    task automatic reset_check();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_rdy%0d", k), 128'(rdy[k]), 128'd0);
            chk($sformatf("rst_rsv%0d", k), 128'(rsv[k]), 128'd0);
            chk($sformatf("rst_rsd%0d", k), rsd[k], 128'd0);
            chk($sformatf("rst_rse%0d", k), 128'(rse[k]), 128'd0);
            chk($sformatf("rst_maddr%0d", k), 128'(maddr[k]), 128'd0);
            chk($sformatf("rst_mext%0d", k), 128'(mext[k]), 128'd0);
            chk($sformatf("rst_mlb%0d", k), 128'(mlb[k]), 128'd0);
            chk($sformatf("rst_mub%0d", k), 128'(mub[k]), 128'h7f);
        end
    endtask

    task automatic step_check();
        for (int k = 0; k < 2; k++) begin
            logic [1:0] ersv;
            logic [1:0] erdy;
            int g;
            ersv = '0;
            erdy = '0;
            g    = -1;
            if (resp_at[k] == cyc) begin
                ersv[resp_g[k]] = 1'b1;
                e_data[k] = p_data[k];
                e_err[k]  = p_err[k];
            end
            if (cyc >= free_at[k] && rq_valid != 2'b00) begin
                if (rq_valid == 2'b11) g = 1 - last_g[k];
                else                   g = rq_valid[1] ? 1 : 0;
                erdy[g] = 1'b1;
            end
            chk($sformatf("rq_ready%0d", k), 128'(rdy[k]), 128'(erdy));
            chk($sformatf("rs_valid%0d", k), 128'(rsv[k]), 128'(ersv));
            chk($sformatf("rs_data%0d", k), rsd[k], e_data[k]);
            chk($sformatf("rs_error%0d", k), 128'(rse[k]), 128'(e_err[k]));
            chk($sformatf("mem_addr%0d", k), 128'(maddr[k]), 128'(e_addr[k]));
            chk($sformatf("mem_extra%0d", k), 128'(mext[k]), 128'(e_ext[k]));
            chk($sformatf("mem_lb%0d", k), 128'(mlb[k]), 128'(e_lb[k]));
            chk($sformatf("mem_ub%0d", k), 128'(mub[k]), 128'(e_ub[k]));
            if (g >= 0) begin
                last_g[k]  = g;
                free_at[k] = cyc + lat(k) + 1;
                resp_at[k] = free_at[k];
                resp_g[k]  = g;
                e_addr[k]  = rq_addr[g*7 +: 7];
                e_ext[k]   = rq_extra[g*4 +: 4];
                e_lb[k]    = rq_lb[g*7 +: 7];
                e_ub[k]    = rq_ub[g*7 +: 7];
                p_data[k]  = rom_f(e_addr[k], e_ext[k]);
                p_err[k]   = (e_addr[k] < e_lb[k]) || (e_addr[k] > e_ub[k]);
            end
        end
        cyc++;
    endtask

    task automatic set_req(input int r, input logic v, input logic [6:0] a,
                           input logic [3:0] e, input logic [6:0] lb, input logic [6:0] ub);
        rq_valid[r]      = v;
        rq_addr[r*7 +: 7] = a;
        rq_extra[r*4 +: 4] = e;
        rq_lb[r*7 +: 7]   = lb;
        rq_ub[r*7 +: 7]   = ub;
    endtask

    task automatic clear_req();
        set_req(0, 1'b0, 7'd0, 4'd0, 7'd0, 7'h7f);
        set_req(1, 1'b0, 7'd0, 4'd0, 7'd0, 7'h7f);
    endtask

    task automatic rand_req();
        for (int r = 0; r < 2; r++) begin
            logic [6:0] lb;
            logic [6:0] ub;
            lb = 7'd0;
            ub = 7'h7f;
            if ($urandom_range(0, 3) == 0) begin
                lb = 7'($urandom_range(0, 127));
                ub = 7'($urandom_range(0, 127));
            end
            set_req(r, $urandom_range(0, 9) < 7, 7'($urandom_range(0, 127)),
                    4'($urandom_range(0, 15)), lb, ub);
        end
    endtask

    // Check the cycle, then advance to just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        step_check();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_req();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_check();
        reset = 1'b0;

        // Single fetch by requester 0.
        set_req(0, 1'b1, 7'd17, 4'd0, 7'd0, 7'd127);
        cycle();
        clear_req();
        repeat (6) cycle();

        // Both requesters continuously valid: strict alternation.
        set_req(0, 1'b1, 7'd4, 4'd0, 7'd0, 7'd127);
        set_req(1, 1'b1, 7'd9, 4'd0, 7'd0, 7'd127);
        repeat (24) cycle();
        clear_req();
        repeat (6) cycle();

        // Requester 1 outside its own window.
        set_req(1, 1'b1, 7'd40, 4'd2, 7'd20, 7'd30);
        cycle();
        clear_req();
        repeat (6) cycle();

        // Random traffic, including withdrawals and field changes.
        repeat (2000) begin
            rand_req();
            cycle();
        end
        clear_req();
        repeat (6) cycle();

        // Asynchronous reset in the middle of WAIT.
        set_req(0, 1'b1, 7'd33, 4'd1, 7'd0, 7'd127);
        cycle();
        clear_req();
        #2;
        reset = 1'b1;
        #1;
        reset_check();
        repeat (4) begin
            @(negedge clk);
            chk("rst_rsv0", 128'(rsv[0]), 128'd0);
            chk("rst_rsv1", 128'(rsv[1]), 128'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_req(0, 1'b1, 7'd5, 4'd3, 7'd0, 7'd127);
        set_req(1, 1'b1, 7'd6, 4'd3, 7'd0, 7'd127);
        cycle();
        repeat (300) begin
            rand_req();
            cycle();
        end
        clear_req();
        repeat (6) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
